// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data round-robin arbiter onto one fixed-latency memory port
module mem_port_arbiter #(
   parameter int MEM_LAT = 2
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        IReq,
   input  logic [31:0] IAddr,
   output logic        IReady,
   output logic [31:0] IRData,
   input  logic        DReq,
   input  logic        DWrite,
   input  logic [31:0] DAddr,
   input  logic [31:0] DWData,
   output logic        DReady,
   output logic [31:0] DRData,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   output logic        MemWE,
   input  logic [31:0] MemRData,
   output logic        ArbBusy
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_last_d;
   logic        r_grant_d;
   logic        r_write;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_irdata;
   logic [31:0] r_drdata;
   logic        r_iready;
   logic        r_dready;
   logic        r_we;
   logic        w_req_any;
   logic        w_pick_d;
   logic [31:0] w_sel_addr;

   assign w_req_any  = IReq | DReq;
   // Round-robin only decides ties; a lone requester always wins.
   assign w_pick_d   = DReq & (~IReq | ~r_last_d);
   assign w_sel_addr = w_pick_d ? DAddr : IAddr;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_req_any) w_state_nxt = BUSY;
         BUSY:    if (r_cnt == 4'd0) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_last_d  <= 1'b0;
         r_grant_d <= 1'b0;
         r_write   <= 1'b0;
         r_cnt     <= 4'd0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_irdata  <= 32'd0;
         r_drdata  <= 32'd0;
         r_iready  <= 1'b0;
         r_dready  <= 1'b0;
         r_we      <= 1'b0;
      end else begin
         r_iready <= 1'b0;
         r_dready <= 1'b0;
         r_we     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req_any) begin
                  r_grant_d <= w_pick_d;
                  r_last_d  <= w_pick_d;
                  r_write   <= w_pick_d & DWrite;
                  r_we      <= w_pick_d & DWrite;
                  r_addr    <= w_sel_addr & 32'hFFFF_FFFC;
                  r_cnt     <= 4'(MEM_LAT - 1);
                  if (w_pick_d) r_wdata <= DWData;
               end
            end
            BUSY: begin
               if (r_cnt == 4'd0) begin
                  // Writes complete with a Ready but leave the read-data registers untouched.
                  if (!r_write) begin
                     if (r_grant_d) r_drdata <= MemRData;
                     else           r_irdata <= MemRData;
                  end
                  r_iready <= ~r_grant_d;
                  r_dready <= r_grant_d;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign IReady   = r_iready;
   assign DReady   = r_dready;
   assign IRData   = r_irdata;
   assign DRData   = r_drdata;
   assign MemAddr  = r_addr;
   assign MemWData = r_wdata;
   assign MemWE    = r_we;
   assign ArbBusy  = (r_state != IDLE);
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, giving memory read latency in cycles (legal 1..15).
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port IReq  input  1  instruction-fetch request, held until IReady.
REQ-005 SHALL have port IAddr  input  32  fetch byte address.
REQ-006 SHALL have port IReady  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port IRData  output  32  registered fetch data.
REQ-008 SHALL have port DReq  input  1  data-cache miss/writeback request, held until DReady.
REQ-009 SHALL have port DWrite  input  1  1 = writeback, 0 = refill read.
REQ-010 SHALL have port DAddr  input  32  data byte address.
REQ-011 SHALL have port DWData  input  32  writeback data.
REQ-012 SHALL have port DReady  output  1  one-cycle data completion pulse.
REQ-013 SHALL have port DRData  output  32  registered refill data.
REQ-014 SHALL have port MemAddr  output  32  shared memory address.
REQ-015 SHALL have port MemWData  output  32  shared memory write data.
REQ-016 SHALL have port MemWE  output  1  shared memory write enable.
REQ-017 SHALL have port MemRData  input  32  memory read data, valid MEM_LAT cycles after address.
REQ-018 SHALL have port ArbBusy  output  1  high whenever state != IDLE; used as pipeline stall.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-020 IDLE: on an edge with IReq or DReq high, SHALL accept one requester, latch its address (bits [1:0] forced 0), write flag and write data, load latency counter with MEM_LAT-1, and enter BUSY.
REQ-021 Simultaneous IReq and DReq SHALL grant the requester not granted last; LastGrant resets to I, so D wins the first tie.
REQ-022 A single requester SHALL be granted regardless of LastGrant; LastGrant updates on every accept.
REQ-023 BUSY: MemAddr/MemWData SHALL drive latched values; MemWE high only in first BUSY cycle and only for a D write; counter decrements each cycle; at 0, state enters RESP and, for reads, MemRData is captured into IRData or DRData for the granted side.
REQ-024 RESP: exactly one of IReady/DReady SHALL be high for one cycle; next state IDLE unconditionally; no request accepted in RESP.
REQ-025 Acceptance-to-Ready latency SHALL be MEM_LAT+1 cycles; back-to-back service period MEM_LAT+2 cycles.
REQ-026 DWrite completion SHALL pulse DReady and leave DRData unchanged; IRData/DRData otherwise hold between reads.
REQ-027 A request deasserted while BUSY SHALL NOT abort the transaction; Ready still pulses.
REQ-028 In IDLE, MemWE SHALL be 0 and MemAddr/MemWData hold last latched values.
REQ-029 ArbBusy SHALL be combinational from state and be high in BUSY and RESP.

Reset
REQ-030 Reset low SHALL immediately force IDLE, LastGrant=I, counter=0, IReady=DReady=MemWE=0, MemAddr=MemWData=IRData=DRData=0, regardless of state.
REQ-031 After Reset rises, first accept SHALL occur no earlier than the next rising edge; a transaction interrupted by reset SHALL never produce a Ready.

Verification
REQ-032 MEM_LAT=2, IReq=1, IAddr=0x0000_0103, memory returns 0xE3A0_1005 -> MemAddr=0x0000_0100, IReady pulses 3 cycles after accept, IRData=0xE3A0_1005.
REQ-033 IReq and DReq both high from reset -> D served first, I accepted in IDLE after DReady, IReady 4 cycles after DReady.
REQ-034 DReq=1, DWrite=1, DAddr=0x40, DWData=0xDEAD_BEEF -> MemWE high for exactly one cycle with MemAddr=0x40, DReady pulses, DRData unchanged.
REQ-035 Both requests held continuously for 6 transactions -> grants alternate D,I,D,I,D,I; ArbBusy low exactly one cycle between each.
REQ-036 Reset asserted in BUSY cycle of a D read -> all outputs 0 at once, no DReady after release, following tie grants D.
REQ-037 MEM_LAT=1 and MEM_LAT=15 -> Ready latency 2 and 16 cycles respectively.
